// File: rtl/decap_stripper_if.sv
// AXI-Stream bundle used on both sides of the tunnel decapsulator.
interface decap_stripper_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 1
);
  logic [DATA_W-1:0]   tdata;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/decap_stripper.sv
// Strips outer tunnel headers from ingress packets and re-aligns the inner frame
// to byte 0 of the bus; strip mode is looked up per packet by tid.
module decap_stripper #(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_ID_WIDTH    = 4,
  parameter int AXIS_DEST_WIDTH  = 0,
  parameter int ALLOW_VLAN_STRIP = 1,
  localparam int EFF_ID_WIDTH    = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1,
  localparam int EFF_DEST_WIDTH  = (AXIS_DEST_WIDTH > 1) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  decap_stripper_if.slave         axis_in,
  decap_stripper_if.master        axis_out,
  output logic [EFF_ID_WIDTH-1:0] decap_config_sel,
  input  logic [3:0]              decap_config_regs,
  output logic                    decap_runt_drop
);
  localparam int N  = AXIS_BUS_WIDTH / 8;
  localparam int NL = $clog2(N);
  localparam int CW = NL + 7;
  localparam logic [CW-1:0] NB = CW'(N);

  typedef enum logic [1:0] {HDR, ALIGN, BODY, FLUSH} state_e;
  typedef enum logic [1:0] {C_NONE, C_DROP, C_ALGN, C_BODY} cls_e;

  state_e state_q, state_d;
  cls_e   cls;
  logic [CW-1:0] cnt_q, cnt_d, d_q, d_d, s_q, s_d, flk_q, flk_d;
  logic [CW-1:0] hdr_len, cfg_dd, cfg_ss, eff_d, eff_s, k_in;
  logic [AXIS_BUS_WIDTH-1:0] held_q, held_d, odata_q, odata_d;
  logic [N-1:0] okeep_q, okeep_d;
  logic olast_q, olast_d, ovalid_q, ovalid_d, runt_q, runt_d;
  logic [EFF_ID_WIDTH-1:0]   tid_q, tid_d, otid_q, otid_d, eff_tid;
  logic [EFF_DEST_WIDTH-1:0] tdest_q, tdest_d, otdest_q, otdest_d, eff_tdest;
  logic sop, out_en, in_fire;

  function automatic logic [N-1:0] ones(input logic [CW-1:0] n);
    logic [N-1:0] all1;
    all1 = '1;
    return all1 >> (NB - n);
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
    unique case (decap_config_regs[2:0])
      3'd1:       hdr_len = CW'(14);
      3'd2:       hdr_len = CW'(34);
      3'd3, 3'd4: hdr_len = CW'(42);
      3'd5:       hdr_len = CW'(50);
      default:    hdr_len = '0;
    endcase
    if (ALLOW_VLAN_STRIP != 0 && decap_config_regs[3] && hdr_len != '0)
      hdr_len = hdr_len + CW'(4);
  end

  assign cfg_dd           = hdr_len >> NL;
  assign cfg_ss           = hdr_len & (NB - CW'(1));
  assign decap_config_sel = axis_in.tid;
  // The SOP beat must be classified with the not-yet-latched config.
  assign sop       = (state_q == HDR) && (cnt_q == '0);
  assign eff_d     = sop ? cfg_dd : d_q;
  assign eff_s     = sop ? cfg_ss : s_q;
  assign eff_tid   = sop ? axis_in.tid : tid_q;
  assign eff_tdest = sop ? axis_in.tdest : tdest_q;
  assign k_in      = popcnt(axis_in.tkeep);

  // Output / classification process
  always_comb begin
    out_en = !ovalid_q || axis_out.tready;
    unique case (state_q)
      HDR:     cls = (cnt_q < eff_d) ? C_DROP : ((eff_s != '0) ? C_ALGN : C_BODY);
      ALIGN:   cls = C_ALGN;
      BODY:    cls = C_BODY;
      default: cls = C_NONE;
    endcase
    axis_in.tready = (cls == C_BODY) ? out_en : (cls != C_NONE);
    in_fire        = axis_in.tvalid && axis_in.tready;
  end

  // Next-state process
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;   held_d = held_q;  flk_d = flk_q;
    d_d = d_q;          s_d = s_q;       tid_d = tid_q;    tdest_d = tdest_q;
    odata_d = odata_q;  okeep_d = okeep_q; olast_d = olast_q;
    otid_d = otid_q;    otdest_d = otdest_q;
    ovalid_d = ovalid_q && !out_en;
    runt_d = 1'b0;
    if (in_fire && sop) begin
      d_d = cfg_dd;  s_d = cfg_ss;  tid_d = axis_in.tid;  tdest_d = axis_in.tdest;
    end
    if (state_q == FLUSH) begin
      if (out_en) begin
        odata_d  = held_q >> {s_q, 3'b000};
        okeep_d  = ones(flk_q);
        olast_d  = 1'b1;
        ovalid_d = 1'b1;
        otid_d   = tid_q;
        otdest_d = tdest_q;
        state_d  = HDR;
        cnt_d    = '0;
      end
    end else if (in_fire) begin
      unique case (cls)
        C_DROP: begin
          if (axis_in.tlast) begin
            runt_d = 1'b1;  state_d = HDR;  cnt_d = '0;
          end else if (cnt_q + CW'(1) == eff_d) begin
            state_d = (eff_s != '0) ? ALIGN : BODY;  cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        C_ALGN: begin
          held_d = axis_in.tdata;
          cnt_d  = '0;
          if (!axis_in.tlast) state_d = BODY;
          else if (k_in > eff_s) begin
            flk_d = k_in - eff_s;  state_d = FLUSH;
          end else begin
            runt_d = 1'b1;  state_d = HDR;
          end
        end
        C_BODY: begin
          ovalid_d = 1'b1;
          otid_d   = eff_tid;
          otdest_d = eff_tdest;
          held_d   = axis_in.tdata;
          cnt_d    = '0;
          state_d  = axis_in.tlast ? HDR : BODY;
          olast_d  = axis_in.tlast;
          if (eff_s == '0) begin
            odata_d = axis_in.tdata;
            okeep_d = axis_in.tkeep;
          end else begin
            odata_d = (held_q >> {eff_s, 3'b000}) | (axis_in.tdata << {NB - eff_s, 3'b000});
            okeep_d = '1;
            if (axis_in.tlast && k_in <= eff_s) okeep_d = ones(NB - eff_s + k_in);
            else if (axis_in.tlast) begin
              olast_d = 1'b0;  flk_d = k_in - eff_s;  state_d = FLUSH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register process
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HDR;  cnt_q <= '0;  held_q <= '0;  flk_q <= '0;
      d_q <= '0;  s_q <= '0;  tid_q <= '0;  tdest_q <= '0;
      odata_q <= '0;  okeep_q <= '0;  olast_q <= 1'b0;  ovalid_q <= 1'b0;
      otid_q <= '0;  otdest_q <= '0;  runt_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  held_q <= held_d;  flk_q <= flk_d;
      d_q <= d_d;  s_q <= s_d;  tid_q <= tid_d;  tdest_q <= tdest_d;
      odata_q <= odata_d;  okeep_q <= okeep_d;  olast_q <= olast_d;  ovalid_q <= ovalid_d;
      otid_q <= otid_d;  otdest_q <= otdest_d;  runt_q <= runt_d;
    end
  end

  assign axis_out.tdata   = odata_q;
  assign axis_out.tkeep   = okeep_q;
  assign axis_out.tlast   = olast_q;
  assign axis_out.tvalid  = ovalid_q;
  assign axis_out.tid     = otid_q;
  assign axis_out.tdest   = otdest_q;
  assign decap_runt_drop  = runt_q;
endmodule

// File: tb/tb_decap_stripper.sv
// Randomised bench for decap_stripper against a byte-queue model of header removal.
`timescale 1ns/1ps
module tb_decap_stripper;
  localparam int W = 64;
  localparam int N = 8;
  typedef struct packed {
    logic [W-1:0] data; logic [N-1:0] keep; logic last; logic [3:0] tid; logic [0:0] tdest;
  } beat_t;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0, aresetn = 1'b0;
  logic [3:0] cfg_sel, cfg_regs, cfg_tbl [16];
  logic runt;
  int checks = 0, failures = 0, rdy_mode = 0, runt_seen = 0, runt_exp = 0;
  beat_t got_q[$], exp_q[$];

  decap_stripper_if #(.DATA_W(W), .ID_W(4), .DEST_W(1)) in_if ();
  decap_stripper_if #(.DATA_W(W), .ID_W(4), .DEST_W(1)) out_if ();

  decap_stripper #(.AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0),
                   .ALLOW_VLAN_STRIP(1)) dut (
    .aclk(clk), .aresetn(aresetn), .axis_in(in_if), .axis_out(out_if),
    .decap_config_sel(cfg_sel), .decap_config_regs(cfg_regs), .decap_runt_drop(runt));

  assign cfg_regs = cfg_tbl[cfg_sel];
  always #5 clk = ~clk;

  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_if.tready = 1'b1;
      else if (rdy_mode == 1) out_if.tready = ~out_if.tready;
      else out_if.tready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: collects accepted beats and holds stalled beats to account.
  initial begin
    beat_t raw, held; logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) stall_prev = 1'b0;
      else begin
        raw = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tid, out_if.tdest};
        if (stall_prev) begin
          checks++;
          if (!out_if.tvalid || raw !== held) begin
            failures++;
            $display("FAIL stall_stable got=%h valid=%b exp=%h", raw, out_if.tvalid, held);
          end
        end
        stall_prev = out_if.tvalid && !out_if.tready;
        held = raw;
        if (out_if.tvalid && out_if.tready) begin
          for (int j = 0; j < N; j++) if (!raw.keep[j]) raw.data[8*j +: 8] = 8'h00;
          got_q.push_back(raw);
        end
        if (runt) runt_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int hdr_len_of(input logic [3:0] cfg);
    int l;
    case (cfg[2:0])
      3'd1: l = 14;  3'd2: l = 34;  3'd3: l = 42;  3'd4: l = 42;  3'd5: l = 50;
      default: l = 0;
    endcase
    if (cfg[3] && l != 0) l += 4;
    return l;
  endfunction

  function automatic void model_pkt(input byte_q_t bytes, input logic [3:0] cfg,
                                    input logic [3:0] tid, input logic tdest);
    int l, p;
    beat_t e;
    l = hdr_len_of(cfg);
    if (bytes.size() <= l) begin runt_exp++; return; end
    p = bytes.size() - l;
    for (int b = 0; b < p; b += N) begin
      e = '0;
      for (int j = 0; j < N; j++)
        if (b + j < p) begin e.data[8*j +: 8] = bytes[l + b + j]; e.keep[j] = 1'b1; end
      e.last = (b + N >= p);  e.tid = tid;  e.tdest = tdest;
      exp_q.push_back(e);
    end
  endfunction

  function automatic byte_q_t mk_bytes(input int len, input int rnd);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(rnd != 0 ? 8'($urandom) : 8'(i));
    return q;
  endfunction

  task automatic drive_beat(input logic [W-1:0] d, input logic [N-1:0] k, input logic l,
                            input logic [3:0] id, input logic de);
    int n;
    logic acc;
    n = 0;
    in_if.tdata = d;  in_if.tkeep = k;  in_if.tlast = l;  in_if.tid = id;  in_if.tdest = de;
    in_if.tvalid = 1'b1;
    do begin
      @(negedge clk); acc = in_if.tready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 300);
    if (!acc) begin checks++; failures++; $display("FAIL in_accept timeout got=0 exp=1"); end
    in_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t bytes, input logic [3:0] cfg, input logic [3:0] tid,
                          input logic tdest, input int gaps);
    logic [W-1:0] d;
    logic [N-1:0] k;
    cfg_tbl[tid] = cfg;
    model_pkt(bytes, cfg, tid, tdest);
    for (int b = 0; b < bytes.size(); b += N) begin
      d = '0;  k = '0;
      for (int j = 0; j < N; j++)
        if (b + j < bytes.size()) begin d[8*j +: 8] = bytes[b + j]; k[j] = 1'b1; end
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(d, k, (b + N >= bytes.size()), tid, tdest);
    end
  endtask

  task automatic clear_sb();
    got_q.delete();  exp_q.delete();  runt_seen = 0;  runt_exp = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 600) begin @(posedge clk); #1; n++; end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    in_if.tvalid = 1'b0;  in_if.tdata = '0;  in_if.tkeep = '0;  in_if.tlast = 1'b0;
    in_if.tid = '0;  in_if.tdest = '0;
    for (int i = 0; i < 16; i++) cfg_tbl[i] = 4'h0;
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_if.tvalid, out_if.tlast, out_if.tkeep, out_if.tdata, out_if.tid, out_if.tdest} !== '0) begin
      failures++;
      $display("FAIL reset_out got v=%b l=%b k=%h d=%h id=%h de=%h exp all zero", out_if.tvalid,
               out_if.tlast, out_if.tkeep, out_if.tdata, out_if.tid, out_if.tdest);
    end
    checks++;
    if (runt !== 1'b0) begin failures++; $display("FAIL reset_runt got=%b exp=0", runt); end
    checks++;
    if (in_if.tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b exp=1", in_if.tready); end
  endtask

  task automatic test_passthrough();
    clear_sb();  rdy_mode = 0;
    send_pkt(mk_bytes(24, 0), 4'h0, 4'd5, 1'b1, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL pass_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pass_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mac();
    clear_sb();  rdy_mode = 0;
    send_pkt(mk_bytes(64, 0), 4'h1, 4'd3, 1'b0, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL mac_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mac_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_vxlan_vlan();
    clear_sb();  rdy_mode = 0;
    send_pkt(mk_bytes(60, 0), 4'hD, 4'd7, 1'b1, 0);
    send_pkt(mk_bytes(56, 1), 4'hD, 4'd7, 1'b0, 0);
    send_pkt(mk_bytes(54, 1), 4'hD, 4'd7, 1'b0, 0);
    send_pkt(mk_bytes(70, 1), 4'hD, 4'd8, 1'b1, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL vx_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL vx_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (runt_seen !== runt_exp) begin failures++; $display("FAIL vx_runt got=%0d exp=%0d", runt_seen, runt_exp); end
  endtask

  task automatic test_runt();
    clear_sb();  rdy_mode = 0;
    send_pkt(mk_bytes(30, 1), 4'h2, 4'd1, 1'b0, 0);
    send_pkt(mk_bytes(45, 1), 4'h2, 4'd1, 1'b1, 0);
    send_pkt(mk_bytes(42, 1), 4'h3, 4'd2, 1'b0, 0);
    send_pkt(mk_bytes(43, 1), 4'h3, 4'd2, 1'b0, 0);
    drain();
    checks++;
    if (runt_seen !== runt_exp) begin failures++; $display("FAIL runt_pulses got=%0d exp=%0d", runt_seen, runt_exp); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL runt_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL runt_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_sb();  rdy_mode = 1;
    send_pkt(mk_bytes(128, 1), 4'h3, 4'd4, 1'b1, 0);
    send_pkt(mk_bytes(93, 1), 4'h1, 4'd6, 1'b0, 0);
    drain();
    rdy_mode = 0;
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_body();
    byte_q_t q;
    logic [W-1:0] d;
    rdy_mode = 0;
    q = mk_bytes(64, 0);
    cfg_tbl[2] = 4'h1;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < N; j++) d[8*j +: 8] = q[b*N + j];
      drive_beat(d, 8'hFF, 1'b0, 4'd2, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (out_if.tvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", out_if.tvalid); end
    aresetn = 1'b0;
    #1;
    checks++;
    if (out_if.tvalid !== 1'b0 || out_if.tkeep !== '0) begin
      failures++; $display("FAIL rst_async got v=%b k=%h exp v=0 k=00", out_if.tvalid, out_if.tkeep);
    end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    clear_sb();
    send_pkt(mk_bytes(64, 1), 4'h4, 4'd9, 1'b1, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rst_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    clear_sb();  rdy_mode = 2;
    for (int p = 0; p < 30; p++)
      send_pkt(mk_bytes($urandom_range(1, 120), 1), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
    drain();
    rdy_mode = 0;
    checks++;
    if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (runt_seen !== runt_exp) begin failures++; $display("FAIL rnd_runt got=%0d exp=%0d", runt_seen, runt_exp); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mac();
    test_vxlan_vlan();
    test_runt();
    test_backpressure();
    test_reset_mid_body();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
